// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, owner codes
// and requester indices used by the top and the aging counters.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
    typedef enum logic [1:0] {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DBG} arb_owner_e;

    localparam logic [2:0] FUNCT3_WORD = 3'b010;

    localparam int NUM_REQ   = 3;
    localparam int REQ_DATA  = 0;
    localparam int REQ_FETCH = 1;
    localparam int REQ_DBG   = 2;
endpackage

// File: rtl/arb_age_ctr.sv
// Saturating per-requester aging counter; promoted flags a requester that has
// lost MAX_WAIT arbitration rounds in a row.
module arb_age_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    input  logic hold,
    output logic promoted
);
    localparam logic [3:0] MAX_AGE = 4'(MAX_WAIT);

    logic [3:0] age;

    // hold beats clr so a halted fetch keeps its accumulated age
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else if (!hold) begin
            if (clr)
                age <= '0;
            else if (inc && age != MAX_AGE)
                age <= age + 4'd1;
        end
    end

    assign promoted = (age == MAX_AGE);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for data, fetch and debug requesters: fixed
// priority data > fetch > dbg with aging promotion, one transfer per round.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              halt_i,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_ack,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    input  logic              g_req,
    input  logic              g_we,
    input  logic [ADDR_W-1:0] g_addr,
    input  logic [DATA_W-1:0] g_wdata,
    output logic              g_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              d_stall,
    output logic              f_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_funct3,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);
    arb_state_e         state;
    arb_owner_e         owner_q;
    logic [NUM_REQ-1:0] req, elig, promoted, cand, pick;
    logic [NUM_REQ-1:0] age_inc, age_clr, age_hold;
    logic               grant;

    assign req  = {g_req, f_req, d_req};
    assign elig = {g_req, f_req & ~halt_i, d_req};

    // Promoted requesters pre-empt plain priority; within each class lowest index wins
    always_comb begin
        cand = elig & promoted;
        if (cand == '0)
            cand = elig;
        pick = '0;
        if (cand[REQ_DATA])
            pick[REQ_DATA] = 1'b1;
        else if (cand[REQ_FETCH])
            pick[REQ_FETCH] = 1'b1;
        else if (cand[REQ_DBG])
            pick[REQ_DBG] = 1'b1;
    end

    assign grant    = (state == IDLE) && (pick != '0);
    assign age_inc  = grant ? (elig & ~pick) : '0;
    assign age_clr  = ~req | (grant ? pick : '0);
    assign age_hold = {1'b0, halt_i, 1'b0};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_age
        arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_age (
            .clk      (clk),
            .reset    (reset),
            .inc      (age_inc[i]),
            .clr      (age_clr[i]),
            .hold     (age_hold[i]),
            .promoted (promoted[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_q    <= OWN_NONE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_funct3 <= '0;
            rdata      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        mem_req <= 1'b1;
                        state   <= BUSY;
                        if (pick[REQ_DATA]) begin
                            owner_q    <= OWN_DATA;
                            mem_we     <= d_we;
                            mem_addr   <= d_addr;
                            mem_wdata  <= d_wdata;
                            mem_funct3 <= d_funct3;
                        end else if (pick[REQ_FETCH]) begin
                            owner_q    <= OWN_FETCH;
                            mem_we     <= 1'b0;
                            mem_addr   <= f_addr;
                            mem_funct3 <= FUNCT3_WORD;
                        end else begin
                            owner_q    <= OWN_DBG;
                            mem_we     <= g_we;
                            mem_addr   <= g_addr;
                            mem_wdata  <= g_wdata;
                            mem_funct3 <= FUNCT3_WORD;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (!mem_we)
                            rdata <= mem_rdata;
                        state <= RESP;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    owner_q <= OWN_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Acks are decoded from registered state, so each lasts exactly the RESP cycle
    assign d_ack   = (state == RESP) && (owner_q == OWN_DATA);
    assign f_ack   = (state == RESP) && (owner_q == OWN_FETCH);
    assign g_ack   = (state == RESP) && (owner_q == OWN_DBG);
    assign d_stall = d_req & ~d_ack;
    assign f_stall = f_req & ~f_ack;
    assign owner   = owner_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: table-driven grant vectors, a
// completion scoreboard, and hand sequences for reset, latency, aging and halt.
module tb_mem_port_arbiter;
    logic        clk = 1'b0, reset = 1'b1, halt_i;
    logic        d_req, d_we, d_ack, f_req, f_ack, g_req, g_we, g_ack;
    logic [8:0]  d_addr, f_addr, g_addr, mem_addr;
    logic [31:0] d_wdata, g_wdata, rdata, mem_wdata, mem_rdata;
    logic [2:0]  d_funct3, mem_funct3;
    logic        d_stall, f_stall, mem_req, mem_we, mem_ready;
    logic [1:0]  owner;
    logic        model_ready, manual_ready;

    always #5 clk = ~clk;
    assign mem_ready = model_ready | manual_ready;

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk(clk), .reset(reset), .halt_i(halt_i),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_funct3(d_funct3), .d_ack(d_ack),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
        .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata), .g_ack(g_ack),
        .rdata(rdata), .d_stall(d_stall), .f_stall(f_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_funct3(mem_funct3), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .owner(owner)
    );

    typedef struct {
        logic [1:0]  owner;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic        d_req, d_we;
        logic [8:0]  d_addr;
        logic [31:0] d_wdata;
        logic [2:0]  d_f3;
        logic        f_req;
        logic [8:0]  f_addr;
        logic        g_req, g_we;
        logic [8:0]  g_addr;
        logic [31:0] g_wdata;
        logic        halt;
        int          w;
        logic [1:0]  exp_owner;
        logic [8:0]  exp_addr;
        logic        exp_we;
        logic [2:0]  exp_f3;
    } vec_t;

    logic [31:0] mem    [0:127];
    logic [31:0] shadow [0:127];
    exp_t        sb[$];
    logic [31:0] last_rd;
    int          mem_w, wcnt;
    bit          mem_en;
    int          checks = 0, errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected completion, computed from the bench's own shadow memory in service order
    task automatic push(input logic [1:0] own, input logic we, input logic [8:0] addr, input logic [31:0] wd);
        exp_t ex;
        if (we) shadow[addr[8:2]] = wd;
        else    last_rd = shadow[addr[8:2]];
        ex.owner = own;
        ex.rdata = last_rd;
        sb.push_back(ex);
    endtask

    task automatic serve(input string name);
        int n = 0;
        while ((d_req || f_req || g_req) && n < 200) begin
            @(negedge clk);
            n++;
            if (d_ack) d_req = 1'b0;
            if (f_ack) f_req = 1'b0;
            if (g_ack) g_req = 1'b0;
        end
        check({name, "_done"}, 64'({d_req, f_req, g_req}), 64'(0));
    endtask

    // Memory responder: mem_ready after mem_w wait cycles, driven on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            model_ready = 1'b0;
            wcnt = 0;
        end else if (model_ready) begin
            model_ready = 1'b0;
        end else if (mem_req && mem_en) begin
            if (wcnt >= mem_w) begin
                model_ready = 1'b1;
                wcnt = 0;
                if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
                else        mem_rdata = mem[mem_addr[8:2]];
            end else begin
                wcnt++;
            end
        end
    end

    logic [1:0] mon_act;
    exp_t       mon_exp;
    always @(negedge clk) begin
        if (!reset && (d_ack || f_ack || g_ack)) begin
            check("one_ack", 64'($countones({d_ack, f_ack, g_ack})), 64'(1));
            mon_act = d_ack ? 2'd1 : (f_ack ? 2'd2 : 2'd3);
            if (sb.size() == 0) begin
                check("sb_unexpected_ack", 64'(mon_act), 64'(0));
            end else begin
                mon_exp = sb.pop_front();
                check("sb_owner", 64'(mon_act), 64'(mon_exp.owner));
                check("sb_rdata", 64'(rdata), 64'(mon_exp.rdata));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];
    int   n, fcnt, ng;
    logic [1:0] grants[5];
    logic prev;

    initial begin
        vecs[0] = '{1'b1, 1'b1, 9'h040, 32'hDEADBEEF, 3'd2, 1'b1, 9'h010, 1'b0, 1'b0, 9'h000, 32'h0,
                    1'b0, 0, 2'd1, 9'h040, 1'b1, 3'd2};
        vecs[1] = '{1'b1, 1'b0, 9'h044, 32'h0, 3'b100, 1'b0, 9'h000, 1'b0, 1'b0, 9'h000, 32'h0,
                    1'b0, 1, 2'd1, 9'h044, 1'b0, 3'b100};
        vecs[2] = '{1'b0, 1'b0, 9'h000, 32'h0, 3'd0, 1'b1, 9'h014, 1'b1, 1'b0, 9'h100, 32'h0,
                    1'b0, 0, 2'd2, 9'h014, 1'b0, 3'd2};
        vecs[3] = '{1'b0, 1'b0, 9'h000, 32'h0, 3'd0, 1'b0, 9'h000, 1'b1, 1'b1, 9'h030, 32'h55,
                    1'b0, 2, 2'd3, 9'h030, 1'b1, 3'd2};
        vecs[4] = '{1'b1, 1'b0, 9'h030, 32'h0, 3'd0, 1'b1, 9'h018, 1'b1, 1'b0, 9'h044, 32'h0,
                    1'b0, 0, 2'd1, 9'h030, 1'b0, 3'd0};
        vecs[5] = '{1'b0, 1'b0, 9'h000, 32'h0, 3'd0, 1'b0, 9'h000, 1'b1, 1'b0, 9'h100, 32'h0,
                    1'b1, 1, 2'd3, 9'h100, 1'b0, 3'd2};

        halt_i = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 0;
        f_req = 0; f_addr = 0; g_req = 0; g_we = 0; g_addr = 0; g_wdata = 0;
        manual_ready = 0; mem_rdata = 0; mem_w = 0; mem_en = 1; last_rd = 0;
        for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 + 32'(i) * 32'h0001_0101;
        mem[4]  = 32'h0050_0093;
        mem[64] = 32'h1234_5678;
        for (int i = 0; i < 128; i++) shadow[i] = mem[i];

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ctl", 64'({owner, mem_req, mem_we, mem_funct3, d_ack, f_ack, g_ack}), 64'(0));
        check("rst_addr", 64'(mem_addr), 64'(0));
        check("rst_wdata", 64'(mem_wdata), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        reset = 0;

        // Reset mid-BUSY: transfer dropped, late mem_ready ignored
        mem_en = 0;
        @(negedge clk); d_req = 1; d_we = 0; d_addr = 9'h044; d_funct3 = 3'd2;
        @(negedge clk); check("rstmid_busy", 64'({mem_req, owner}), 64'({1'b1, 2'd1}));
        @(negedge clk); #2 reset = 1; #1;
        check("rstmid_drop", 64'({mem_req, owner, d_ack}), 64'(0));
        check("rstmid_addr", 64'(mem_addr), 64'(0));
        @(negedge clk); d_req = 0; reset = 0; manual_ready = 1;
        @(negedge clk); manual_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid_noack", 64'({d_ack, f_ack, g_ack, mem_req}), 64'(0));
        end
        mem_en = 1;

        // Table-driven grant vectors
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            mem_w = vecs[k].w; halt_i = vecs[k].halt;
            d_req = vecs[k].d_req; d_we = vecs[k].d_we; d_addr = vecs[k].d_addr;
            d_wdata = vecs[k].d_wdata; d_funct3 = vecs[k].d_f3;
            f_req = vecs[k].f_req; f_addr = vecs[k].f_addr;
            g_req = vecs[k].g_req; g_we = vecs[k].g_we; g_addr = vecs[k].g_addr; g_wdata = vecs[k].g_wdata;
            if (d_req) push(2'd1, d_we, d_addr, d_wdata);
            if (f_req && !halt_i) push(2'd2, 1'b0, f_addr, 32'h0);
            if (g_req) push(2'd3, g_we, g_addr, g_wdata);
            @(negedge clk);
            check($sformatf("vec%0d_grant", k), 64'({owner, mem_req, mem_addr, mem_we, mem_funct3}),
                  64'({vecs[k].exp_owner, 1'b1, vecs[k].exp_addr, vecs[k].exp_we, vecs[k].exp_f3}));
            if (vecs[k].exp_we)
                check($sformatf("vec%0d_wdata", k), 64'(mem_wdata),
                      64'(vecs[k].exp_owner == 2'd1 ? vecs[k].d_wdata : vecs[k].g_wdata));
            serve($sformatf("vec%0d", k));
            halt_i = 0;
        end

        // Single fetch, W=2: exact latency and stall window
        @(negedge clk); mem_w = 2; f_req = 1; f_addr = 9'h010; push(2'd2, 1'b0, 9'h010, 32'h0);
        #1 check("fetch_stall_n", 64'(f_stall), 64'(1));
        @(negedge clk);
        check("fetch_memreq", 64'({mem_req, mem_addr, mem_funct3, mem_we}), 64'({1'b1, 9'h010, 3'd2, 1'b0}));
        check("fetch_stall_n1", 64'({f_stall, f_ack}), 64'({1'b1, 1'b0}));
        @(negedge clk); check("fetch_n2", 64'({f_stall, f_ack}), 64'({1'b1, 1'b0}));
        @(negedge clk); check("fetch_n3", 64'({f_stall, f_ack}), 64'({1'b1, 1'b0}));
        @(negedge clk); check("fetch_n4_ack", 64'({f_stall, f_ack}), 64'({1'b0, 1'b1}));
        check("fetch_rdata", 64'(rdata), 64'(32'h0050_0093));
        f_req = 0;

        // Starvation: fetch loses four rounds to a continuous data stream
        @(negedge clk); mem_w = 0;
        d_req = 1; d_we = 0; d_addr = 9'h040; d_funct3 = 3'd2; f_req = 1; f_addr = 9'h014;
        for (int i = 0; i < 4; i++) push(2'd1, 1'b0, 9'h040, 32'h0);
        push(2'd2, 1'b0, 9'h014, 32'h0);
        ng = 0; prev = 0;
        for (int c = 0; c < 60 && ng < 5; c++) begin
            @(negedge clk);
            if (mem_req && !prev) begin grants[ng] = owner; ng++; end
            prev = mem_req;
        end
        d_req = 0;
        check("starve_rounds", 64'(ng), 64'(5));
        check("starve_order", 64'({grants[0], grants[1], grants[2], grants[3], grants[4]}),
              64'({2'd1, 2'd1, 2'd1, 2'd1, 2'd2}));
        serve("starve");

        // Halt: only debug is served; fetch resumes after release
        @(negedge clk); mem_w = 1; halt_i = 1;
        f_req = 1; f_addr = 9'h010; g_req = 1; g_we = 0; g_addr = 9'h100;
        push(2'd3, 1'b0, 9'h100, 32'h0);
        n = 0; fcnt = 0;
        while (g_req && n < 50) begin
            @(negedge clk); n++;
            if (f_ack) fcnt++;
            if (g_ack) g_req = 0;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (f_ack || mem_req) fcnt++;
        end
        check("halt_dbg_done", 64'(g_req), 64'(0));
        check("halt_no_fetch", 64'(fcnt), 64'(0));
        halt_i = 0; push(2'd2, 1'b0, 9'h010, 32'h0);
        serve("halt_release");

        // Debug write, W=0: ack on the third cycle, rdata untouched
        @(negedge clk); mem_w = 0; g_req = 1; g_we = 1; g_addr = 9'h020; g_wdata = 32'h0AB;
        push(2'd3, 1'b1, 9'h020, 32'h0AB);
        @(negedge clk); check("wr_n1", 64'(g_ack), 64'(0));
        @(negedge clk); check("wr_n2_ack", 64'(g_ack), 64'(1));
        check("wr_rdata_kept", 64'(rdata), 64'(32'h0050_0093));
        g_req = 0;
        @(negedge clk); check("wr_mem", 64'(mem[8]), 64'(32'h0AB));

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbitrates a single-ported unified memory between three requesters: pipeline data access (MEM stage), instruction fetch (IF stage) and a debug/loader port.
- Fixed priority is data > fetch > dbg.
- Per-requester aging counters stop any requester from starving.
- A halt input freezes fetch service so the debug port can inspect or load memory.
- The block sits between the pipeline stages and the memory. It drives the stall signals the hazard logic combines with load-use stalls.

Parameters:
ADDR_W, 9, memory byte-address width
DATA_W, 32, data width
MAX_WAIT, 4, lost arbitration rounds before a waiting requester is promoted (1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-high reset
halt_i  in  1  while high, fetch requests are ineligible
d_req  in  1  data request; held until d_ack
d_we  in  1  data write enable (1=store, 0=load)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_funct3  in  3  access size/sign, passed to memory
d_ack  out  1  one-cycle completion pulse
f_req  in  1  fetch request (read only)
f_addr  in  ADDR_W  fetch address
f_ack  out  1  one-cycle completion pulse
g_req  in  1  debug request
g_we  in  1  debug write enable
g_addr  in  ADDR_W  debug address
g_wdata  in  DATA_W  debug write data
g_ack  out  1  one-cycle completion pulse
rdata  out  DATA_W  read data, valid while any ack is high
d_stall  out  1  d_req & ~d_ack
f_stall  out  1  f_req & ~f_ack
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_funct3  out  3  access size (3'b010 for fetch and debug)
mem_ready  in  1  one-cycle completion pulse from memory
mem_rdata  in  DATA_W  read data, valid with mem_ready
owner  out  2  current owner: NONE=0, DATA=1, FETCH=2, DBG=3

Behaviour:
- Reset values: state IDLE, owner NONE, mem_req/mem_we/all acks 0, mem_addr/mem_wdata/rdata 0, mem_funct3 0, ages 0.
- Reset takes effect immediately, including mid-transfer. The dropped transfer is never acknowledged.
- FSM states are IDLE, BUSY and RESP.
- IDLE:
  - Eligible requesters are those with req high. Fetch is excluded while halt_i is high.
  - A requester is promoted when its age == MAX_WAIT.
  - Winner: highest-priority promoted requester if any exist, otherwise highest-priority eligible requester.
  - On a win, register the winner's addr, we, wdata and funct3 onto mem_* (fetch: we=0, funct3=3'b010), set owner, set mem_req=1 and go to BUSY.
- BUSY: mem_req and mem_* stay stable. On mem_ready, capture mem_rdata into rdata (write transfers leave rdata unchanged) and go to RESP.
- RESP: the owner's ack is high for exactly this cycle, mem_req=0 and owner is unchanged. Next state is IDLE, where owner becomes NONE.
- The acknowledged requester may keep req high in IDLE; that is treated as a new request.
- Latency: request sampled in IDLE at cycle N → mem_req at N+1 → mem_ready at N+1+W (W ≥ 0 memory wait cycles) → ack at N+2+W. Minimum is 3 cycles per access.
- Aging:
  - In IDLE with a winner, each eligible non-winner's age increments, saturating at MAX_WAIT.
  - The winner's age clears to 0. A requester with req low also clears to 0.
  - While halt_i is high, the fetch age holds its value.
- Requesters hold addr and data stable until ack. The arbiter latches them at grant, so later changes have no effect.
- mem_ready while in IDLE or RESP is ignored.
- Simultaneous requests in IDLE produce exactly one grant per round.
- halt_i rising during a fetch transfer does not abort it. The fetch completes and is acknowledged.
- mem_addr and mem_wdata carry no wrap logic. Addresses pass through unmodified.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic[1:0] arb_state_e {IDLE, BUSY, RESP}
  - typedef enum logic[1:0] arb_owner_e {OWN_NONE, OWN_DATA, OWN_FETCH, OWN_DBG}
  - localparam FUNCT3_WORD=3'b010
- One sub-module, arb_age_ctr: a saturating counter with inc/clr/hold controls and a promoted output, instantiated three times.

Test Plan:
- Reset: assert reset mid-BUSY → mem_req drops in the same cycle; a later mem_ready produces no ack; all outputs are 0 and owner=0.
- Single fetch: f_addr=0x010, memory W=2 returning 0x00500093 → mem_req at N+1 with mem_addr=0x010, mem_funct3=2 → f_ack at N+4 with rdata=0x00500093; f_stall high N..N+3.
- Contention: d_req store (addr 0x040, wdata 0xDEADBEEF, funct3=2) and f_req in the same cycle → data granted first (mem_we=1); fetch granted in the next IDLE; d_ack precedes f_ack, each one cycle.
- Starvation (MAX_WAIT=4): d_req held continuously with f_req pending, W=0 → fetch loses 4 IDLE rounds, then is granted in the 5th; owner=2.
- Halt: halt_i=1, f_req and g_req (read 0x100) pending → only the debug transfer occurs, g_ack with rdata from 0x100; f_ack never fires; after halt_i falls, fetch is served.
- Write return: debug write 0x0AB to 0x020 with W=0 → g_ack 3 cycles after request; rdata keeps its previous value.
